// File: rtl/sim_memory_model_pkg.sv
// Shared types and constants for the simulation memory model request sequencer.
// Request word layout, MSB first: {write, mask[3:0], addr[AW-1:0], data[31:0]}.
package sim_memory_model_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } seq_state_t;

  localparam int DATA_W   = 32;
  localparam int LANES    = 4;
  localparam int LANE_W   = 8;
  localparam int MASK_W   = LANES;
  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = DATA_W;

  function automatic int mask_lsb(input int aw);
    return DATA_W + aw;
  endfunction

  function automatic int write_bit(input int aw);
    return DATA_W + aw + MASK_W;
  endfunction

  function automatic int req_width(input int aw);
    return 1 + MASK_W + aw + DATA_W;
  endfunction

  // Expand per-lane enables into a per-bit write mask.
  function automatic logic [DATA_W-1:0] lane_bits(input logic [LANES-1:0] be);
    logic [DATA_W-1:0] bits;
    bits = '0;
    for (int i = 0; i < LANES; i++) begin
      bits[LANE_W*i +: LANE_W] = {LANE_W{be[i]}};
    end
    return bits;
  endfunction

endpackage

// File: rtl/sim_memory_model_ram.sv
// Single-port word array: asynchronous read, byte-enabled synchronous write,
// every word cleared by the asynchronous reset.
module sim_memory_model_ram
  import sim_memory_model_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic              iCLOCK,
  input  logic              inRESET,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [LANES-1:0]  be,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DATA_W-1:0] bit_en_s;
  logic [DATA_W-1:0] words_s [DEPTH];

  assign bit_en_s = lane_bits(be);

  for (genvar w = 0; w < DEPTH; w++) begin : g_word
    logic [DATA_W-1:0] word_r;

    // Word storage with lane-merged write.
    always_ff @(posedge iCLOCK or negedge inRESET) begin
      if (!inRESET) begin
        word_r <= '0;
      end else if (we && (addr == AW'(w))) begin
        word_r <= (word_r & ~bit_en_s) | (wdata & bit_en_s);
      end
    end

    assign words_s[w] = word_r;
  end

  assign rdata = words_s[addr];

endmodule

// File: rtl/sim_memory_model_req_sequencer.sv
// Pops requests from the request FIFO, executes them after LATENCY edges, pushes
// read data to the response FIFO. SIM_MEMORY_MODEL_BYTE_MASK_EN enables byte-masked writes.
module sim_memory_model_req_sequencer
  import sim_memory_model_pkg::*;
#(
  parameter int AW      = 10,
  parameter int DW      = DATA_W,
  parameter int LATENCY = 3,
  parameter int REQ_W   = req_width(AW)
) (
  input  logic             iCLOCK,
  input  logic             inRESET,
  input  logic             iREMOVE,
  input  logic             iREQ_EMPTY,
  input  logic [REQ_W-1:0] iREQ_DATA,
  output logic             oREQ_RD_EN,
  input  logic             iRSP_FULL,
  output logic             oRSP_WR_EN,
  output logic [DW-1:0]    oRSP_DATA,
  output logic             oBUSY,
  output logic [15:0]      oOP_COUNT
);

  localparam logic [3:0] LAT_C = 4'(LATENCY);

  seq_state_t       state_r;
  logic [3:0]       cnt_r;
  logic [REQ_W-1:0] req_r;
  logic [DW-1:0]    rsp_data_r;
  logic [15:0]      op_count_r;

  logic             pop_s;
  logic             push_s;
  logic             exec_s;
  logic             req_write_s;
  logic [MASK_W-1:0] req_mask_s;
  logic [AW-1:0]    req_addr_s;
  logic [DW-1:0]    req_wdata_s;
  logic [DW-1:0]    ram_rdata_s;
  logic [LANES-1:0] ram_be_s;
  logic             ram_we_s;

  assign req_write_s = req_r[write_bit(AW)];
  assign req_mask_s  = req_r[mask_lsb(AW) +: MASK_W];
  assign req_addr_s  = req_r[ADDR_LSB +: AW];
  assign req_wdata_s = req_r[DATA_LSB +: DW];

  assign pop_s  = (state_r == IDLE) && !iREQ_EMPTY && !iREMOVE;
  assign push_s = (state_r == RESP) && !iRSP_FULL && !iREMOVE;
  assign exec_s = (state_r == WAIT) && (cnt_r == 4'd1) && !iREMOVE;

  assign ram_we_s = exec_s && req_write_s;

`ifdef SIM_MEMORY_MODEL_BYTE_MASK_EN
  assign ram_be_s = req_mask_s;
`else
  // Mask field travels with the request but full-word writes ignore it.
  logic unused_mask_s;
  assign unused_mask_s = ^req_mask_s;
  assign ram_be_s      = {LANES{1'b1}};
`endif

  sim_memory_model_ram #(
    .AW (AW)
  ) u_ram (
    .iCLOCK  (iCLOCK),
    .inRESET (inRESET),
    .we      (ram_we_s),
    .addr    (req_addr_s),
    .wdata   (req_wdata_s),
    .be      (ram_be_s),
    .rdata   (ram_rdata_s)
  );

  // Sequencer FSM: flush has priority over execute and push.
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      req_r      <= '0;
      rsp_data_r <= '0;
      op_count_r <= 16'd0;
    end else if (iREMOVE) begin
      state_r    <= IDLE;
      cnt_r      <= 4'd0;
      op_count_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pop_s) begin
            state_r <= WAIT;
            cnt_r   <= LAT_C;
            req_r   <= iREQ_DATA;
          end
        end
        WAIT: begin
          if (cnt_r == 4'd1) begin
            cnt_r <= 4'd0;
            if (req_write_s) begin
              op_count_r <= op_count_r + 16'd1;
              state_r    <= IDLE;
            end else begin
              rsp_data_r <= ram_rdata_s;
              state_r    <= RESP;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        RESP: begin
          if (push_s) begin
            op_count_r <= op_count_r + 16'd1;
            state_r    <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
        end
      endcase
    end
  end

  assign oREQ_RD_EN = pop_s;
  assign oRSP_WR_EN = push_s;
  assign oRSP_DATA  = rsp_data_r;
  assign oBUSY      = (state_r != IDLE);
  assign oOP_COUNT  = op_count_r;

endmodule

// File: tb/tb_sim_memory_model_req_sequencer.sv
// Directed self-checking bench for sim_memory_model_req_sequencer (LATENCY=3, AW=10).
// Expected byte-mask result follows SIM_MEMORY_MODEL_BYTE_MASK_EN.
module tb_sim_memory_model_req_sequencer;

  localparam int AW  = 10;
  localparam int LAT = 3;

  logic        iCLOCK;
  logic        inRESET;
  logic        iREMOVE;
  logic        iREQ_EMPTY;
  logic [46:0] iREQ_DATA;
  logic        oREQ_RD_EN;
  logic        iRSP_FULL;
  logic        oRSP_WR_EN;
  logic [31:0] oRSP_DATA;
  logic        oBUSY;
  logic [15:0] oOP_COUNT;

  int n_checks = 0;
  int n_fails  = 0;
  int push_cnt = 0;

  sim_memory_model_req_sequencer #(
    .AW      (AW),
    .LATENCY (LAT)
  ) dut (
    .iCLOCK     (iCLOCK),
    .inRESET    (inRESET),
    .iREMOVE    (iREMOVE),
    .iREQ_EMPTY (iREQ_EMPTY),
    .iREQ_DATA  (iREQ_DATA),
    .oREQ_RD_EN (oREQ_RD_EN),
    .iRSP_FULL  (iRSP_FULL),
    .oRSP_WR_EN (oRSP_WR_EN),
    .oRSP_DATA  (oRSP_DATA),
    .oBUSY      (oBUSY),
    .oOP_COUNT  (oOP_COUNT)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  always @(posedge iCLOCK) begin
    if (oRSP_WR_EN) push_cnt <= push_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Called at a negedge with the sequencer idle; returns at the negedge after execute.
  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] m);
    iREQ_DATA  = {1'b1, m, a, d};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    repeat (LAT) @(negedge iCLOCK);
  endtask

  task automatic do_read(input logic [9:0] a, output logic [31:0] d);
    iREQ_DATA  = {1'b0, 4'h0, a, 32'h0};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    repeat (LAT) @(negedge iCLOCK);
    #1;
    d = oRSP_DATA;
    @(negedge iCLOCK);
  endtask

  logic [31:0] rd;
  logic [31:0] mask_exp;
  int          pushes_before;
  int          pop_cyc [3];
  int          npop;
  int          idx;
  logic        busy_log [16];
  logic        rd_seen;
  logic [31:0] wq [3];

  initial begin
    inRESET    = 1'b0;
    iREMOVE    = 1'b0;
    iREQ_EMPTY = 1'b1;
    iREQ_DATA  = '0;
    iRSP_FULL  = 1'b0;
    repeat (3) @(negedge iCLOCK);
    #1;
    check_eq("reset_rd_en", oREQ_RD_EN, 32'd0);
    check_eq("reset_wr_en", oRSP_WR_EN, 32'd0);
    check_eq("reset_rsp_data", oRSP_DATA, 32'd0);
    check_eq("reset_busy", oBUSY, 32'd0);
    check_eq("reset_op_count", oOP_COUNT, 32'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    @(negedge iCLOCK);

    // Write then read back with cycle-exact response timing.
    iREQ_DATA  = {1'b1, 4'hF, 10'h010, 32'hDEADBEEF};
    iREQ_EMPTY = 1'b0;
    #1;
    check_eq("pop_when_idle", oREQ_RD_EN, 32'd1);
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    #1;
    check_eq("busy_after_pop", oBUSY, 32'd1);
    repeat (LAT) @(negedge iCLOCK);
    #1;
    check_eq("write_count", oOP_COUNT, 32'd1);
    check_eq("idle_after_write", oBUSY, 32'd0);

    iREQ_DATA  = {1'b0, 4'h0, 10'h010, 32'h0};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    repeat (LAT - 1) @(negedge iCLOCK);
    #1;
    check_eq("no_push_before_exec", oRSP_WR_EN, 32'd0);
    @(negedge iCLOCK);
    #1;
    check_eq("push_after_exec", oRSP_WR_EN, 32'd1);
    check_eq("read_data", oRSP_DATA, 32'hDEADBEEF);
    @(negedge iCLOCK);
    #1;
    check_eq("read_count", oOP_COUNT, 32'd2);
    check_eq("idle_after_push", oBUSY, 32'd0);

    // Byte-masked write.
    do_write(10'h030, 32'h11223344, 4'hF);
    do_write(10'h030, 32'hAABBCCDD, 4'b0101);
    do_read(10'h030, rd);
`ifdef SIM_MEMORY_MODEL_BYTE_MASK_EN
    mask_exp = 32'h11BB33DD;
`else
    mask_exp = 32'hAABBCCDD;
`endif
    check_eq("mask_merge", rd, mask_exp);
    #1;
    check_eq("mask_count", oOP_COUNT, 32'd5);

    // Response back-pressure, with another request waiting.
    iRSP_FULL  = 1'b1;
    iREQ_DATA  = {1'b0, 4'h0, 10'h010, 32'h0};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    repeat (LAT) @(negedge iCLOCK);
    iREQ_EMPTY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_eq("bp_no_push", oRSP_WR_EN, 32'd0);
      check_eq("bp_no_pop", oREQ_RD_EN, 32'd0);
      check_eq("bp_data_hold", oRSP_DATA, 32'hDEADBEEF);
      @(negedge iCLOCK);
    end
    iRSP_FULL  = 1'b0;
    iREQ_EMPTY = 1'b1;
    #1;
    check_eq("bp_push_on_release", oRSP_WR_EN, 32'd1);
    pushes_before = push_cnt;
    @(negedge iCLOCK);
    #1;
    check_eq("bp_single_push", push_cnt - pushes_before, 32'd1);
    check_eq("bp_count", oOP_COUNT, 32'd6);

    // Three queued writes.
    wq[0] = 32'hA0000001;
    wq[1] = 32'hA0000002;
    wq[2] = 32'hA0000003;
    idx  = 0;
    npop = 0;
    iREQ_DATA  = {1'b1, 4'hF, 10'h100, wq[0]};
    iREQ_EMPTY = 1'b0;
    for (int c = 0; c < 16; c++) begin
      #1;
      rd_seen     = oREQ_RD_EN;
      busy_log[c] = oBUSY;
      if (rd_seen) begin
        if (npop < 3) pop_cyc[npop] = c;
        npop++;
      end
      @(negedge iCLOCK);
      if (rd_seen) begin
        idx++;
        if (idx < 3) iREQ_DATA = {1'b1, 4'hF, 10'h100 + 10'(idx), wq[idx]};
        else iREQ_EMPTY = 1'b1;
      end
    end
    check_eq("b2b_pop_total", npop, 32'd3);
    check_eq("b2b_pop0", pop_cyc[0], 32'd0);
    check_eq("b2b_pop1", pop_cyc[1], 32'd4);
    check_eq("b2b_pop2", pop_cyc[2], 32'd8);
    check_eq("b2b_busy_before_fall", busy_log[11], 32'd1);
    check_eq("b2b_busy_fall", busy_log[12], 32'd0);
    do_read(10'h101, rd);
    check_eq("b2b_data", rd, 32'hA0000002);
    #1;
    check_eq("b2b_count", oOP_COUNT, 32'd10);

    // Flush during WAIT discards the pending write.
    do_write(10'h020, 32'h00000005, 4'hF);
    iREQ_DATA  = {1'b1, 4'hF, 10'h020, 32'h00000099};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    iREMOVE    = 1'b1;
    @(negedge iCLOCK);
    iREMOVE = 1'b0;
    #1;
    check_eq("flush_wait_idle", oBUSY, 32'd0);
    check_eq("flush_wait_count", oOP_COUNT, 32'd0);
    repeat (LAT) @(negedge iCLOCK);
    do_read(10'h020, rd);
    check_eq("flush_wait_array", rd, 32'h00000005);

    // Flush during RESP suppresses the push.
    iREQ_DATA  = {1'b0, 4'h0, 10'h020, 32'h0};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    repeat (LAT) @(negedge iCLOCK);
    pushes_before = push_cnt;
    iREMOVE = 1'b1;
    #1;
    check_eq("flush_resp_no_wr_en", oRSP_WR_EN, 32'd0);
    @(negedge iCLOCK);
    iREMOVE = 1'b0;
    #1;
    check_eq("flush_resp_no_push", push_cnt - pushes_before, 32'd0);
    check_eq("flush_resp_idle", oBUSY, 32'd0);
    check_eq("flush_resp_count", oOP_COUNT, 32'd0);
    check_eq("flush_resp_data_kept", oRSP_DATA, 32'h00000005);

    // Counter wrap: preset near 0xFFFF instead of issuing 65535 writes.
    force dut.op_count_r = 16'hFFFF;
    #1;
    release dut.op_count_r;
    @(negedge iCLOCK);
    do_write(10'h040, 32'h00000001, 4'hF);
    #1;
    check_eq("count_wrap", oOP_COUNT, 32'd0);

    // Asynchronous reset in the middle of a read.
    iREQ_DATA  = {1'b0, 4'h0, 10'h010, 32'h0};
    iREQ_EMPTY = 1'b0;
    @(negedge iCLOCK);
    iREQ_EMPTY = 1'b1;
    @(negedge iCLOCK);
    inRESET = 1'b0;
    #1;
    check_eq("rst_busy", oBUSY, 32'd0);
    check_eq("rst_wr_en", oRSP_WR_EN, 32'd0);
    check_eq("rst_rsp_data", oRSP_DATA, 32'd0);
    check_eq("rst_count", oOP_COUNT, 32'd0);
    @(negedge iCLOCK);
    inRESET = 1'b1;
    @(negedge iCLOCK);
    do_read(10'h010, rd);
    check_eq("rst_array_cleared", rd, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
